// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: independent dividers with shadowed terminal
// counts, free-run or one-shot operation, and a square-wave output per channel.
module tick_gen_multi #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 22,
  parameter int unsigned DEFAULT_TC = 3333334,
  localparam int unsigned SelW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0] arm,
  input  logic                sync_clr,
  input  logic                wr_en,
  input  logic [SelW-1:0]     wr_sel,
  input  logic [WIDTH-1:0]    wr_tc,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq,
  output logic [CHANNELS-1:0] pend,
  output logic [CHANNELS-1:0] active
);

  localparam logic [WIDTH-1:0] DefTc = WIDTH'(DEFAULT_TC);

  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [WIDTH-1:0]    tc_q     [CHANNELS];
  logic [WIDTH-1:0]    tc_d     [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] sq_q, sq_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] active_q, active_d;

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] at_tc;
  logic [CHANNELS-1:0] running;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] xfer;

  // Out-of-range selects match no channel and are dropped.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en && (32'(wr_sel) == i);
    end
  end

  always_comb begin
    at_tc   = '0;
    running = '0;
    wrap    = '0;
    xfer    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      at_tc[i]   = (cnt_q[i] == tc_q[i]);
      // A one-shot channel also runs out a period that was started in free-run mode.
      running[i] = !mode[i] || active_q[i] || (cnt_q[i] != '0);
      wrap[i]    = !sync_clr && enable[i] && running[i] && at_tc[i];
      xfer[i]    = pend_q[i] && (sync_clr || !enable[i] || wrap[i]);
    end
  end

  always_comb begin
    tick_d   = '0;
    sq_d     = sq_q;
    pend_d   = pend_q;
    active_d = active_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = cnt_q[i];
      // Transfer takes the pre-write shadow; a coincident write re-arms pend.
      tc_d[i]     = xfer[i] ? shadow_q[i] : tc_q[i];
      shadow_d[i] = wr_hit[i] ? wr_tc : shadow_q[i];
      pend_d[i]   = wr_hit[i] || (pend_q[i] && !xfer[i]);
      active_d[i] = active_q[i] && mode[i];

      if (sync_clr) begin
        cnt_d[i]    = '0;
        sq_d[i]     = 1'b0;
        active_d[i] = 1'b0;
      end else if (!enable[i]) begin
        if (pend_q[i]) begin
          cnt_d[i] = '0;
        end
      end else if (wrap[i]) begin
        cnt_d[i]    = '0;
        tick_d[i]   = 1'b1;
        sq_d[i]     = ~sq_q[i];
        active_d[i] = 1'b0;
      end else if (running[i]) begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end else if (arm[i]) begin
        active_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= '0;
        tc_q[i]     <= DefTc;
        shadow_q[i] <= DefTc;
      end
      tick_q   <= '0;
      sq_q     <= '0;
      pend_q   <= '0;
      active_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
      pend_q   <= pend_d;
      active_q <= active_d;
    end
  end

  assign tick   = tick_q;
  assign sq     = sq_q;
  assign pend   = pend_q;
  assign active = active_q;

endmodule
